fifo_unpack: RTL and testbench

Read-side width converter that sits directly downstream of the parameterizable `fifo`. It pops WIDTH-bit words from the FIFO's first-word-fall-through read port and emits them as a stream of OUT_WIDTH-bit chunks over a valid/ready handshake. Typical use: draining 32-bit FIFO words into byte-wide consumers such as a UART transmitter or byte bus, sustaining one chunk per cycle with no bubbles between words.

---
 rtl/fifo_unpack.sv | 84 ++++++++
 tb/tb_fifo_unpack.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_unpack.sv
// Read-side width converter: pops WIDTH-bit words from a FWFT FIFO
// and streams them out as OUT_WIDTH-bit chunks over valid/ready.
module fifo_unpack #(
  parameter int WIDTH     = 32,
  parameter int OUT_WIDTH = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     fifo_dout,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [15:0]          words_popped
);

  localparam int R  = WIDTH / OUT_WIDTH;
  localparam int IW = (R > 1) ? $clog2(R) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(R - 1);

  logic [WIDTH-1:0] sh_q, sh_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             vld_q, vld_d;
  logic [15:0]      cnt_q, cnt_d;

  logic accept;
  logic last;
  logic slot_free;

  assign last       = vld_q & (idx_q == IDX_LAST);
  assign accept     = vld_q & out_ready;
  assign slot_free  = ~vld_q | (accept & last);
  // No path from fifo_dout, so no loop through the FIFO.
  assign fifo_rd_en = ~reset & ~fifo_empty & slot_free;

  always_comb begin
    sh_d  = sh_q;
    idx_d = idx_q;
    vld_d = vld_q;
    cnt_d = cnt_q;
    if (fifo_rd_en) begin
      sh_d  = fifo_dout;
      idx_d = '0;
      vld_d = 1'b1;
      cnt_d = cnt_q + 16'd1;
    end else if (accept && !last) begin
      if (MSB_FIRST) sh_d = sh_q << OUT_WIDTH;
      else           sh_d = sh_q >> OUT_WIDTH;
      idx_d = idx_q + 1'b1;
    end else if (accept && last) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q  <= '0;
      idx_q <= '0;
      vld_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      idx_q <= idx_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  generate
    if (MSB_FIRST) begin : g_msb
      assign out_data = sh_q[WIDTH-1 -: OUT_WIDTH];
    end else begin : g_lsb
      assign out_data = sh_q[OUT_WIDTH-1:0];
    end
  endgenerate

  assign out_valid    = vld_q;
  assign out_last     = last;
  assign words_popped = cnt_q;

endmodule

// File: tb/tb_fifo_unpack.sv
// Bench for fifo_unpack: LSB-first and MSB-first instances, each fed
// by a queue-modelled FWFT FIFO and checked against a chunk scoreboard.
module tb_fifo_unpack;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [31:0] fdo [2];
  logic        fe  [2];
  logic        rd  [2];
  logic [7:0]  od  [2];
  logic        ov  [2];
  logic        ol  [2];
  logic [15:0] wp  [2];

  logic [31:0] fq [2][$];
  logic [8:0]  eq [2][$];
  logic        held [2];
  logic [8:0]  hd   [2];
  int          nvld [2];
  int          nrd  [2];
  logic [15:0] pop_m [2];

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fifo_unpack #(.WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(rst),
    .fifo_dout(fdo[0]), .fifo_empty(fe[0]), .fifo_rd_en(rd[0]),
    .out_data(od[0]), .out_valid(ov[0]), .out_ready(rdy),
    .out_last(ol[0]), .words_popped(wp[0])
  );

  fifo_unpack #(.WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(rst),
    .fifo_dout(fdo[1]), .fifo_empty(fe[1]), .fifo_rd_en(rd[1]),
    .out_data(od[1]), .out_valid(ov[1]), .out_ready(rdy),
    .out_last(ol[1]), .words_popped(wp[1])
  );

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  task automatic refresh();
    for (int d = 0; d < 2; d++) begin
      fe[d]  = (fq[d].size() == 0);
      fdo[d] = fe[d] ? 32'h0 : fq[d][0];
    end
  endtask

  task automatic push_word(input int d, input logic [31:0] w);
    logic [7:0] c;
    fq[d].push_back(w);
    for (int i = 0; i < 4; i++) begin
      c = (d == 1) ? w[31-8*i -: 8] : w[8*i +: 8];
      eq[d].push_back({(i == 3), c});
    end
    refresh();
  endtask

  task automatic clr_cnt();
    for (int d = 0; d < 2; d++) begin
      nvld[d] = 0;
      nrd[d]  = 0;
    end
  endtask

  task automatic step();
    logic [31:0] e;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rd_when_empty", 32'(rd[d] & fe[d]), 32'h0);
      if (held[d]) chk("hold", {23'h0, ol[d], od[d]}, {23'h0, hd[d]});
      held[d] = ov[d] & ~rdy & ~rst;
      hd[d]   = {ol[d], od[d]};
      if (ov[d]) nvld[d]++;
      if (rd[d]) begin
        nrd[d]++;
        if (ov[d]) chk("rd_on_last", 32'(ol[d] & rdy), 32'h1);
        if (fq[d].size() > 0) void'(fq[d].pop_front());
        pop_m[d] = pop_m[d] + 16'd1;
      end
      if (ov[d] && rdy && !rst) begin
        e = (eq[d].size() > 0) ? {23'h0, eq[d].pop_front()} : 32'hDEAD;
        chk("chunk", {23'h0, ol[d], od[d]}, e);
      end
    end
    @(posedge clk);
    #1;
    refresh();
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b0;
    for (int d = 0; d < 2; d++) begin
      held[d]  = 1'b0;
      hd[d]    = '0;
      pop_m[d] = '0;
    end
    clr_cnt();
    refresh();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", 32'(ov[d]), 32'h0);
      chk("rst_last",  32'(ol[d]), 32'h0);
      chk("rst_data",  32'(od[d]), 32'h0);
      chk("rst_wp",    32'(wp[d]), 32'h0);
    end
    // A word waiting in the FIFO must not be popped during reset.
    push_word(0, 32'h44332211);
    #1;
    chk("rd_in_reset", 32'(rd[0]), 32'h0);
    step();

    // single word
    rst = 1'b0;
    rdy = 1'b1;
    clr_cnt();
    repeat (5) step();
    chk("t1_drain", 32'(eq[0].size()), 32'h0);
    repeat (2) step();
    chk("t1_nvld", 32'(nvld[0]), 32'd4);
    chk("t1_nrd",  32'(nrd[0]),  32'd1);
    chk("t1_wp",   32'(wp[0]),   32'd1);
    chk("t1_idle", 32'(ov[0]),   32'h0);

    // back-to-back words, no bubbles
    clr_cnt();
    push_word(0, 32'h44332211);
    push_word(0, 32'h88776655);
    repeat (9) step();
    chk("t2_drain", 32'(eq[0].size()), 32'h0);
    chk("t2_nvld",  32'(nvld[0]), 32'd8);
    chk("t2_nrd",   32'(nrd[0]),  32'd2);
    chk("t2_wp",    32'(wp[0]),   32'd3);
    step();
    chk("t2_idle",  32'(ov[0]),   32'h0);

    // alternating backpressure
    clr_cnt();
    push_word(0, 32'h44332211);
    push_word(0, 32'h88776655);
    for (int i = 0; i < 20; i++) begin
      rdy = i[0];
      step();
    end
    rdy = 1'b1;
    repeat (3) step();
    chk("t3_drain", 32'(eq[0].size()), 32'h0);
    chk("t3_nrd",   32'(nrd[0]), 32'd2);
    chk("t3_wp",    32'(wp[0]),  32'd5);

    // reset mid-word
    push_word(0, 32'h44332211);
    push_word(0, 32'hCCBBAA99);
    repeat (3) step();
    // 0x33 and 0x44 are discarded by the reset
    void'(eq[0].pop_front());
    void'(eq[0].pop_front());
    rst = 1'b1;
    rdy = 1'b0;
    step();
    pop_m[0] = '0;
    pop_m[1] = '0;
    chk("t4_valid", 32'(ov[0]), 32'h0);
    chk("t4_wp",    32'(wp[0]), 32'h0);
    chk("t4_data",  32'(od[0]), 32'h0);
    rst = 1'b0;
    rdy = 1'b1;
    repeat (6) step();
    chk("t4_drain", 32'(eq[0].size()), 32'h0);
    chk("t4_wp2",   32'(wp[0]), 32'd1);
    chk("t4_wp_m",  32'(wp[0]), 32'(pop_m[0]));

    // long empty stretch
    clr_cnt();
    repeat (100) step();
    chk("t5_nrd",  32'(nrd[0] + nrd[1]),   32'h0);
    chk("t5_nvld", 32'(nvld[0] + nvld[1]), 32'h0);

    // MSB-first instance
    clr_cnt();
    push_word(1, 32'h44332211);
    repeat (6) step();
    chk("t6_drain", 32'(eq[1].size()), 32'h0);
    chk("t6_nvld",  32'(nvld[1]), 32'd4);
    chk("t6_wp",    32'(wp[1]),   32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
